// File: rtl/regfile_rn.sv
// regfile_rn: renaming register file for the out-of-order core.
// Holds the architectural value of every register plus a ROB-tag rename map.
// Operand reads are combinational with same-cycle commit bypass; renames come
// from decode (one per cycle) and commits from the ROB (up to NCMT per cycle).
// Register 0 is hardwired to tag 0 / value 0.
module regfile_rn #(
  parameter int NREG  = 32,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  parameter int NCMT  = 2,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [NRD*RW-1:0]     i_rd_idx,
  output logic [NRD*TAG_W-1:0]  o_rd_tag,
  output logic [NRD*XLEN-1:0]   o_rd_val,
  input  logic                  i_rn_ena,
  input  logic [RW-1:0]         i_rn_rd,
  input  logic [TAG_W-1:0]      i_rn_tag,
  input  logic [NCMT-1:0]       i_cm_ena,
  input  logic [NCMT*RW-1:0]    i_cm_rd,
  input  logic [NCMT*TAG_W-1:0] i_cm_tag,
  input  logic [NCMT*XLEN-1:0]  i_cm_val,
  output logic [CW-1:0]         o_busy_cnt
);

  logic [TAG_W-1:0]     r_tag [NREG];
  logic [XLEN-1:0]      r_val [NREG];
  logic [CW-1:0]        r_busy_cnt;

  logic [TAG_W-1:0]     w_tag_nxt [NREG];
  logic [XLEN-1:0]      w_val_nxt [NREG];
  logic [CW-1:0]        w_busy_nxt;
  logic                 w_rn_go;
  logic [NRD*TAG_W-1:0] w_rd_tag;
  logic [NRD*XLEN-1:0]  w_rd_val;

  // A rename only lands when enabled, requested, not stalled and not flushed.
  assign w_rn_go = i_en & i_rn_ena & ~i_stall & ~i_flush;

  // Next-state tags/values: commit writes, then rename override, then flush.
  always_comb begin
    logic w_hit;
    w_hit      = 1'b0;
    w_busy_nxt = {CW{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      w_tag_nxt[r] = r_tag[r];
      w_val_nxt[r] = r_val[r];
    end
    for (int r = 1; r < NREG; r++) begin
      // Later (younger) commit ports overwrite earlier ones on collision.
      // Tag clears compare against the pre-edge tag so stale commits miss.
      for (int k = 0; k < NCMT; k++) begin
        w_hit = i_en & i_cm_ena[k] & (i_cm_rd[k*RW +: RW] == RW'(r));
        if (w_hit) begin
          w_val_nxt[r] = i_cm_val[k*XLEN +: XLEN];
          if (r_tag[r] == i_cm_tag[k*TAG_W +: TAG_W]) begin
            w_tag_nxt[r] = {TAG_W{1'b0}};
          end else begin
            w_tag_nxt[r] = w_tag_nxt[r];
          end
        end else begin
          w_val_nxt[r] = w_val_nxt[r];
        end
      end
      if (w_rn_go && (i_rn_rd == RW'(r))) begin
        w_tag_nxt[r] = i_rn_tag;
      end else begin
        w_tag_nxt[r] = w_tag_nxt[r];
      end
      if (i_flush) begin
        w_tag_nxt[r] = {TAG_W{1'b0}};
      end else begin
        w_tag_nxt[r] = w_tag_nxt[r];
      end
    end
    w_tag_nxt[0] = {TAG_W{1'b0}};
    w_val_nxt[0] = {XLEN{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      w_busy_nxt = w_busy_nxt + CW'(w_tag_nxt[r] != {TAG_W{1'b0}});
    end
  end

  // Operand reads: current state with same-cycle commit bypass (ignores en).
  always_comb begin
    logic [RW-1:0] w_idx;
    logic          w_clr;
    logic          w_match;
    w_rd_tag = {(NRD*TAG_W){1'b0}};
    w_rd_val = {(NRD*XLEN){1'b0}};
    w_idx    = {RW{1'b0}};
    w_clr    = 1'b0;
    w_match  = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      w_idx = i_rd_idx[p*RW +: RW];
      w_clr = 1'b0;
      w_rd_val[p*XLEN +: XLEN] = r_val[w_idx];
      for (int k = 0; k < NCMT; k++) begin
        w_match = i_cm_ena[k] & (i_cm_rd[k*RW +: RW] == w_idx);
        if (w_match && (w_idx != {RW{1'b0}})) begin
          w_rd_val[p*XLEN +: XLEN] = i_cm_val[k*XLEN +: XLEN];
        end else begin
          w_rd_val[p*XLEN +: XLEN] = w_rd_val[p*XLEN +: XLEN];
        end
        if (w_match && (i_cm_tag[k*TAG_W +: TAG_W] == r_tag[w_idx])) begin
          w_clr = 1'b1;
        end else begin
          w_clr = w_clr;
        end
      end
      w_rd_tag[p*TAG_W +: TAG_W] = w_clr ? {TAG_W{1'b0}} : r_tag[w_idx];
    end
  end

  assign o_rd_tag   = w_rd_tag;
  assign o_rd_val   = w_rd_val;
  assign o_busy_cnt = r_busy_cnt;

  // State registers: rename map, architectural values and busy count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_tag[r] <= {TAG_W{1'b0}};
        r_val[r] <= {XLEN{1'b0}};
      end
      r_busy_cnt <= {CW{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_tag[r] <= w_tag_nxt[r];
        r_val[r] <= w_val_nxt[r];
      end
      r_busy_cnt <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_rn.sv
// Testbench for regfile_rn: directed vector table, then random traffic
// compared with a behavioural model, plus an asynchronous reset mid-burst.
module tb_regfile_rn;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en, i_stall, i_flush, i_rn_ena;
  logic [9:0]  i_rd_idx;
  logic [7:0]  o_rd_tag;
  logic [63:0] o_rd_val;
  logic [4:0]  i_rn_rd;
  logic [3:0]  i_rn_tag;
  logic [1:0]  i_cm_ena;
  logic [9:0]  i_cm_rd;
  logic [7:0]  i_cm_tag;
  logic [63:0] i_cm_val;
  logic [5:0]  o_busy_cnt;

  regfile_rn dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_stall(i_stall),
    .i_flush(i_flush), .i_rd_idx(i_rd_idx), .o_rd_tag(o_rd_tag),
    .o_rd_val(o_rd_val), .i_rn_ena(i_rn_ena), .i_rn_rd(i_rn_rd),
    .i_rn_tag(i_rn_tag), .i_cm_ena(i_cm_ena), .i_cm_rd(i_cm_rd),
    .i_cm_tag(i_cm_tag), .i_cm_val(i_cm_val), .o_busy_cnt(o_busy_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en, stall, flush, rn_ena;
    logic [4:0]  rn_rd;
    logic [3:0]  rn_tag;
    logic [1:0]  cm_ena;
    logic [4:0]  c0_rd, c1_rd;
    logic [3:0]  c0_tag, c1_tag;
    logic [31:0] c0_val, c1_val;
    logic [4:0]  rd0, rd1;
    logic [3:0]  et0, et1;
    logic [31:0] ev0, ev1;
    logic [5:0]  ebusy;
  } vec_t;

  function automatic vec_t mk(
    input logic en, input logic stall, input logic flush,
    input logic rn, input logic [4:0] rnrd, input logic [3:0] rntag,
    input logic [1:0] cme,
    input logic [4:0] c0rd, input logic [3:0] c0tag, input logic [31:0] c0val,
    input logic [4:0] c1rd, input logic [3:0] c1tag, input logic [31:0] c1val,
    input logic [4:0] rd0, input logic [4:0] rd1,
    input logic [3:0] et0, input logic [31:0] ev0,
    input logic [3:0] et1, input logic [31:0] ev1,
    input logic [5:0] eb);
    vec_t v;
    v.en = en; v.stall = stall; v.flush = flush; v.rn_ena = rn;
    v.rn_rd = rnrd; v.rn_tag = rntag; v.cm_ena = cme;
    v.c0_rd = c0rd; v.c0_tag = c0tag; v.c0_val = c0val;
    v.c1_rd = c1rd; v.c1_tag = c1tag; v.c1_val = c1val;
    v.rd0 = rd0; v.rd1 = rd1; v.et0 = et0; v.ev0 = ev0;
    v.et1 = et1; v.ev1 = ev1; v.ebusy = eb;
    return v;
  endfunction

  // Behavioural reference state
  logic [3:0]  m_tag [32];
  logic [31:0] m_val [32];

  function automatic logic [31:0] mdl_val(input logic [4:0] r);
    logic [31:0] v;
    v = m_val[r];
    if (i_cm_ena[0] && i_cm_rd[4:0] == r && r != 5'd0) v = i_cm_val[31:0];
    if (i_cm_ena[1] && i_cm_rd[9:5] == r && r != 5'd0) v = i_cm_val[63:32];
    return v;
  endfunction

  function automatic logic [3:0] mdl_tag(input logic [4:0] r);
    if (i_cm_ena[0] && i_cm_rd[4:0] == r && i_cm_tag[3:0] == m_tag[r]) return 4'd0;
    if (i_cm_ena[1] && i_cm_rd[9:5] == r && i_cm_tag[7:4] == m_tag[r]) return 4'd0;
    return m_tag[r];
  endfunction

  // Applies one clock edge worth of architectural effect to the model.
  task automatic mdl_step();
    logic [3:0]  nt [32];
    logic [31:0] nv [32];
    for (int r = 0; r < 32; r++) begin nt[r] = m_tag[r]; nv[r] = m_val[r]; end
    if (i_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [4:0] rd;
        rd = (k == 0) ? i_cm_rd[4:0] : i_cm_rd[9:5];
        if (i_cm_ena[k] && rd != 5'd0) begin
          nv[rd] = (k == 0) ? i_cm_val[31:0] : i_cm_val[63:32];
          if (m_tag[rd] == ((k == 0) ? i_cm_tag[3:0] : i_cm_tag[7:4])) nt[rd] = 4'd0;
        end
      end
      if (i_rn_ena && !i_stall && !i_flush && i_rn_rd != 5'd0) nt[i_rn_rd] = i_rn_tag;
    end
    if (i_flush) for (int r = 0; r < 32; r++) nt[r] = 4'd0;
    for (int r = 0; r < 32; r++) begin m_tag[r] = nt[r]; m_val[r] = nv[r]; end
  endtask

  function automatic int mdl_busy();
    int c;
    c = 0;
    for (int r = 0; r < 32; r++) if (m_tag[r] != 4'd0) c++;
    return c;
  endfunction

  task automatic mdl_clear();
    for (int r = 0; r < 32; r++) begin m_tag[r] = 4'd0; m_val[r] = 32'd0; end
  endtask

  task automatic idle_inputs();
    i_en = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_rn_ena = 1'b0;
    i_rn_rd = 5'd0; i_rn_tag = 4'd0; i_cm_ena = 2'b00; i_cm_rd = 10'd0;
    i_cm_tag = 8'd0; i_cm_val = 64'd0; i_rd_idx = 10'd0;
  endtask

  vec_t tbl [27];

  initial begin
    tbl[0]  = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  5,0, 0,0,0,0, 0);
    tbl[1]  = mk(1,0,0, 0,0,0, 2'b01, 0,0,32'hDEAD,     0,0,0,  0,5, 0,0,0,0, 0);
    tbl[2]  = mk(1,0,0, 1,3,4, 2'b00, 0,0,0,            0,0,0,  3,0, 0,0,0,0, 1);
    tbl[3]  = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  3,0, 4,0,0,0, 1);
    tbl[4]  = mk(1,0,0, 0,0,0, 2'b01, 3,4,32'h11,       0,0,0,  3,0, 0,32'h11,0,0, 0);
    tbl[5]  = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  3,0, 0,32'h11,0,0, 0);
    tbl[6]  = mk(1,0,0, 1,3,4, 2'b00, 0,0,0,            0,0,0,  3,0, 0,32'h11,0,0, 1);
    tbl[7]  = mk(1,0,0, 1,3,7, 2'b00, 0,0,0,            0,0,0,  3,0, 4,32'h11,0,0, 1);
    tbl[8]  = mk(1,0,0, 0,0,0, 2'b01, 3,4,32'h22,       0,0,0,  3,0, 7,32'h22,0,0, 1);
    tbl[9]  = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  3,0, 7,32'h22,0,0, 1);
    tbl[10] = mk(1,0,0, 1,3,9, 2'b10, 0,0,0,            3,7,32'h33, 3,0, 0,32'h33,0,0, 1);
    tbl[11] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  3,0, 9,32'h33,0,0, 1);
    tbl[12] = mk(1,0,0, 1,6,5, 2'b00, 0,0,0,            0,0,0,  6,3, 0,0,9,32'h33, 2);
    tbl[13] = mk(1,0,0, 0,0,0, 2'b11, 6,3,32'h1,        6,5,32'h2, 6,3, 0,32'h2,9,32'h33, 1);
    tbl[14] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  6,3, 0,32'h2,9,32'h33, 1);
    tbl[15] = mk(1,1,0, 1,7,6, 2'b01, 3,9,32'h55,       0,0,0,  3,7, 0,32'h55,0,0, 0);
    tbl[16] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  7,3, 0,0,0,32'h55, 0);
    tbl[17] = mk(0,0,0, 1,9,2, 2'b01, 9,0,32'h77,       0,0,0,  9,0, 0,32'h77,0,0, 0);
    tbl[18] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  9,0, 0,0,0,0, 0);
    tbl[19] = mk(1,0,0, 1,1,1, 2'b00, 0,0,0,            0,0,0,  1,2, 0,0,0,0, 1);
    tbl[20] = mk(1,0,0, 1,2,2, 2'b00, 0,0,0,            0,0,0,  1,2, 1,0,0,0, 2);
    tbl[21] = mk(1,0,0, 1,4,3, 2'b00, 0,0,0,            0,0,0,  2,4, 2,0,0,0, 3);
    tbl[22] = mk(1,0,1, 1,8,5, 2'b01, 2,15,32'h44,      0,0,0,  2,8, 2,32'h44,0,0, 0);
    tbl[23] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  2,8, 0,32'h44,0,0, 0);
    tbl[24] = mk(1,0,0, 1,1,1, 2'b00, 0,0,0,            0,0,0,  1,4, 0,0,0,0, 1);
    tbl[25] = mk(0,0,1, 0,0,0, 2'b00, 0,0,0,            0,0,0,  1,4, 1,0,0,0, 0);
    tbl[26] = mk(1,0,0, 0,0,0, 2'b00, 0,0,0,            0,0,0,  1,2, 0,0,0,32'h44, 0);

    // Reset state
    idle_inputs();
    mdl_clear();
    i_rst_n = 1'b0;
    i_rd_idx = {5'd0, 5'd5};
    #12;
    chk("rst_tag", {24'd0, o_rd_tag}, 32'd0);
    chk("rst_val0", o_rd_val[31:0], 32'd0);
    chk("rst_busy", {26'd0, o_busy_cnt}, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed vectors
    for (int i = 0; i < 27; i++) begin
      i_en = tbl[i].en; i_stall = tbl[i].stall; i_flush = tbl[i].flush;
      i_rn_ena = tbl[i].rn_ena; i_rn_rd = tbl[i].rn_rd; i_rn_tag = tbl[i].rn_tag;
      i_cm_ena = tbl[i].cm_ena;
      i_cm_rd  = {tbl[i].c1_rd, tbl[i].c0_rd};
      i_cm_tag = {tbl[i].c1_tag, tbl[i].c0_tag};
      i_cm_val = {tbl[i].c1_val, tbl[i].c0_val};
      i_rd_idx = {tbl[i].rd1, tbl[i].rd0};
      #1;
      chk($sformatf("vec%0d_tag0", i), {28'd0, o_rd_tag[3:0]}, {28'd0, tbl[i].et0});
      chk($sformatf("vec%0d_val0", i), o_rd_val[31:0], tbl[i].ev0);
      chk($sformatf("vec%0d_tag1", i), {28'd0, o_rd_tag[7:4]}, {28'd0, tbl[i].et1});
      chk($sformatf("vec%0d_val1", i), o_rd_val[63:32], tbl[i].ev1);
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d_busy", i), {26'd0, o_busy_cnt}, {26'd0, tbl[i].ebusy});
    end

    // Resynchronise model and DUT with a reset away from the clock edge
    idle_inputs();
    i_rst_n = 1'b0; #2; i_rst_n = 1'b1;
    mdl_clear();
    @(posedge i_clk); #1;

    // Random traffic against the model, with an async reset mid-burst
    for (int c = 0; c < 600; c++) begin
      logic [4:0] r0, r1;
      if (c == 300) begin
        i_rn_ena = 1'b1; i_cm_ena = 2'b00; i_rd_idx = {5'd2, 5'd1};
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_tag", {24'd0, o_rd_tag}, 32'd0);
        chk("midrst_val0", o_rd_val[31:0], 32'd0);
        chk("midrst_val1", o_rd_val[63:32], 32'd0);
        chk("midrst_busy", {26'd0, o_busy_cnt}, 32'd0);
        i_rst_n = 1'b1;
        mdl_clear();
        @(posedge i_clk); #1;
      end
      i_en     = ($urandom % 10) != 0;
      i_stall  = ($urandom % 5) == 0;
      i_flush  = ($urandom % 20) == 0;
      i_rn_ena = $urandom % 2;
      i_rn_rd  = 5'($urandom_range(0, 7));
      i_rn_tag = 4'($urandom_range(1, 15));
      i_cm_ena = 2'($urandom);
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      i_cm_rd  = {r1, r0};
      i_cm_tag = {(($urandom % 2) != 0) ? m_tag[r1] : 4'($urandom),
                  (($urandom % 2) != 0) ? m_tag[r0] : 4'($urandom)};
      i_cm_val = {32'($urandom), 32'($urandom)};
      i_rd_idx = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      chk("rnd_tag0", {28'd0, o_rd_tag[3:0]}, {28'd0, mdl_tag(i_rd_idx[4:0])});
      chk("rnd_val0", o_rd_val[31:0], mdl_val(i_rd_idx[4:0]));
      chk("rnd_tag1", {28'd0, o_rd_tag[7:4]}, {28'd0, mdl_tag(i_rd_idx[9:5])});
      chk("rnd_val1", o_rd_val[63:32], mdl_val(i_rd_idx[9:5]));
      mdl_step();
      @(posedge i_clk); #1;
      chk("rnd_busy", {26'd0, o_busy_cnt}, 32'(mdl_busy()));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_rn.md
# regfile_rn

Parametrised renaming register file for the out-of-order core. It holds the architectural value of every register together with a ROB-tag rename map, and serves the decode unit's operand lookups with same-cycle commit bypass. It takes one rename per cycle from decode and up to NCMT commits per cycle from the ROB. Flush clears every pending tag and keeps the committed values, so rollback costs no architectural state.

## Interface
- NREG, 32: architectural register count, power of two; index width RW = clog2(NREG)
- XLEN, 32: data width
- TAG_W, 4: ROB tag width; tag 0 means "no producer, value ready"
- NRD, 2: operand read ports
- NCMT, 2: commit ports; a higher index is a younger instruction
- clk  in  1  the single clock; every state update is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- en  in  1  global enable; low freezes rename and commit updates
- stall  in  1  blocks rename only; commits still apply
- flush  in  1  rollback; all tags become 0 next cycle
- rd_idx  in  NRD*RW  packed read indices
- rd_tag  out  NRD*TAG_W  producer tag per read port (0 = ready)
- rd_val  out  NRD*XLEN  value per read port
- rn_ena  in  1  rename request
- rn_rd  in  RW  destination register
- rn_tag  in  TAG_W  new producer tag; never 0 when rn_ena is high
- cm_ena  in  NCMT  commit valid per port
- cm_rd  in  NCMT*RW  commit destinations
- cm_tag  in  NCMT*TAG_W  ROB tag of each committing instruction
- cm_val  in  NCMT*XLEN  committed results
- busy_cnt  out  clog2(NREG+1)  registered count of registers with nonzero tag

## Operation
- State: tag[NREG], val[NREG]. Register 0 is hardwired: tag 0, value 0. Writes and renames to it are ignored.
- Reads are combinational from current state plus commit bypass, evaluated per port p and index r:
  - Value: the youngest enabled commit port k with cm_rd==r, r≠0 drives the value (cm_val[k]); otherwise val[r].
  - Tag: if any enabled commit port has cm_rd==r and cm_tag==tag[r], return tag 0; otherwise return tag[r].
  - The same-cycle rename never affects reads. An instruction with rs==rd sees the old mapping.
  - Bypass applies even when en is low, so reads stay consistent with the presented commits.
- Commit, when en is high and flush is don't-care:
  - val[cm_rd] <= cm_val; the youngest port wins on a same-rd collision.
  - tag[cm_rd] <= 0 only if tag[cm_rd]==cm_tag, compared against the pre-edge tag. A stale commit, whose register was renamed again, leaves the tag untouched.
- Rename, when en, rn_ena, !stall and !flush are all high: tag[rn_rd] <= rn_tag. It overrides a same-cycle commit tag clear on the same register. The commit value write still happens.
- Flush: every tag <= 0. A rename in the same cycle is dropped. Commits in the same cycle still write val; flush acts even when en is low.
- busy_cnt <= popcount of the next-state tags, updated every edge, so it always matches state after that edge.

## Timing
- Async reset (rst_n low): all tag=0, all val=0, busy_cnt=0 immediately. rd_tag=0 and rd_val=0 unless a commit bypass is active. State is held until the first rising edge after rst_n goes high.
- Read latency 0 (combinational). Rename and commit become visible in state 1 cycle later. busy_cnt lags by 1 cycle.
- Priority per register: reset > flush (tags) > rename > commit tag clear. Value writes depend only on commit and en.
- en low: no state change except flush; busy_cnt is recomputed from the held tags, so it is unchanged.
- Reset mid-operation discards pending renames and commits of that cycle.

## Test plan
- Reset then read x5/x0 -> tag 0, val 0, busy_cnt 0. Commit x0=0xDEAD -> a read of x0 still returns 0.
- Rename x3->tag 4. Next cycle read x3 -> tag 4, busy_cnt 1. Commit x3 tag 4 val 0x11 -> the same-cycle read gives tag 0, val 0x11; next cycle the state is tag 0, busy_cnt 0.
- Stale commit: rename x3->4, then x3->7. Commit x3 tag 4 val 0x22 -> val=0x22, tag stays 7.
- Same cycle: rename x3->9 and commit x3 tag 7 val 0x33 (tag[x3]=7) -> next tag 9, val 0x33. A read of x3 that cycle -> tag 0, val 0x33.
- Dual commit: port0 x6 val 1, port1 x6 val 2 (tag match on port1) -> val 2, tag 0. Stall high with rn_ena high -> no rename, commits still apply.
- Flush with three busy registers and a concurrent rename x8->5 and commit x2 val 0x44 -> all tags 0, x8 unchanged, x2=0x44, busy_cnt 0 next cycle. Assert rst_n mid-burst -> all outputs 0 with no clock edge.
